// File: rtl/ddr2_sys_chf_pkg.sv
// Shared types for the ddr2_sys Avalon-ST channel filter: FSM states and the
// default-configuration beat carried through the skid buffer.
package ddr2_sys_chf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } chf_state_t;

  localparam int unsigned CHF_DATA_W   = 8;
  localparam int unsigned CHF_IN_CH_W  = 8;
  localparam int unsigned CHF_OUT_CH_W = 2;
  localparam int unsigned CHF_MAX_CH   = 3;
  localparam int unsigned CHF_CNT_W    = 16;

  typedef struct packed {
    logic [CHF_DATA_W-1:0]   data;
    logic [CHF_OUT_CH_W-1:0] channel;
    logic                    sop;
    logic                    eop;
  } chf_beat_t;

endpackage

// File: rtl/ddr2_sys_st_skid_buf.sv
// Two-entry registered skid buffer: main register drives the outputs, skid
// register absorbs one beat while the main register is stalled.
module ddr2_sys_st_skid_buf
  import ddr2_sys_chf_pkg::*;
#(
  parameter type beat_t = chf_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  s_valid_i,
  output logic  s_ready_o,
  input  beat_t s_beat_i,
  output logic  m_valid_o,
  input  logic  m_ready_i,
  output beat_t m_beat_o
);

  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q;
  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  logic  push;
  logic  load_main;

  assign push      = s_valid_i && ready_q;
  assign load_main = !main_valid_q || m_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (load_main) begin
      if (skid_valid_q) begin
        // ready_q is low whenever skid holds a beat, so no push can collide here
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) main_d = s_beat_i;
      end
    end else if (push) begin
      skid_d       = s_beat_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = main_valid_q;
  assign m_beat_o  = main_q;

endmodule

// File: rtl/ddr2_sys_st_channel_filter.sv
// Avalon-ST channel adapter: narrows the channel and discards packets above
// MAX_CHANNEL. Optional drop counter under DDR2_SYS_CHF_DROP_CNT_EN.
module ddr2_sys_st_channel_filter
  import ddr2_sys_chf_pkg::*;
#(
  parameter int unsigned DATA_W      = CHF_DATA_W,
  parameter int unsigned IN_CH_W     = CHF_IN_CH_W,
  parameter int unsigned OUT_CH_W    = CHF_OUT_CH_W,
  parameter int unsigned MAX_CHANNEL = CHF_MAX_CH,
  parameter int unsigned CNT_W       = CHF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                in_ready,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [IN_CH_W-1:0]  in_channel,
  input  logic                in_startofpacket,
  input  logic                in_endofpacket,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [OUT_CH_W-1:0] out_channel,
  output logic                out_startofpacket,
  output logic                out_endofpacket
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]    drop_count
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [OUT_CH_W-1:0] channel;
    logic                sop;
    logic                eop;
  } beat_t;

  localparam logic [IN_CH_W-1:0] MAX_CH = IN_CH_W'(MAX_CHANNEL);

  chf_state_t          state_q, state_d;
  logic [OUT_CH_W-1:0] ch_q, ch_d;
  logic                accept;
  logic                ch_ok;
  logic                fwd;
  beat_t               in_beat;
  beat_t               out_beat;

  assign accept = in_valid && in_ready;
  assign ch_ok  = (in_channel <= MAX_CH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_startofpacket) begin
        if (in_endofpacket) state_d = IDLE;
        else                state_d = ch_ok ? PASS : DROP;
      end else if (in_endofpacket) begin
        state_d = IDLE;
      end
    end
  end

  // A stray non-SOP beat in IDLE carries its own channel, not the latched one
  always_comb begin
    fwd             = 1'b0;
    ch_d            = ch_q;
    in_beat.data    = in_data;
    in_beat.channel = ch_q;
    in_beat.sop     = in_startofpacket;
    in_beat.eop     = in_endofpacket;
    if (accept) begin
      if (in_startofpacket) begin
        if (ch_ok) begin
          fwd             = 1'b1;
          ch_d            = in_channel[OUT_CH_W-1:0];
          in_beat.channel = in_channel[OUT_CH_W-1:0];
        end
      end else begin
        case (state_q)
          PASS:    fwd = 1'b1;
          DROP:    fwd = 1'b0;
          default: begin
            fwd             = ch_ok;
            in_beat.channel = in_channel[OUT_CH_W-1:0];
          end
        endcase
      end
    end
  end

  ddr2_sys_st_skid_buf #(
    .beat_t (beat_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset_n),
    .s_valid_i (fwd),
    .s_ready_o (in_ready),
    .s_beat_i  (in_beat),
    .m_valid_o (out_valid),
    .m_ready_i (out_ready),
    .m_beat_o  (out_beat)
  );

  assign out_data          = out_beat.data;
  assign out_channel       = out_beat.channel;
  assign out_startofpacket = out_beat.sop;
  assign out_endofpacket   = out_beat.eop;

`ifdef DDR2_SYS_CHF_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             drop_sop;

  assign drop_sop = accept && in_startofpacket && !ch_ok;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_sop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ddr2_sys_st_channel_filter.sv
// Directed bench for ddr2_sys_st_channel_filter: forwarding, filtering,
// backpressure and reset behaviour.
module tb_ddr2_sys_st_channel_filter;

  logic       clk;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_channel;
  logic       out_startofpacket;
  logic       out_endofpacket;
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic tb_fwd;

  logic [11:0] got[$];
  int          got_cyc[$];
  logic [11:0] exp[$];

  ddr2_sys_st_channel_filter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_channel        (in_channel),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket)
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      got.push_back({out_data, out_channel, out_startofpacket, out_endofpacket});
      got_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic sop, input logic eop, input logic [7:0] ch,
                       input logic [7:0] data, input logic fwd);
    int w;
    in_valid = 1'b1;
    in_startofpacket = sop;
    in_endofpacket = eop;
    in_channel = ch;
    in_data = data;
    tb_fwd = fwd;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tb_fwd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_channel = '0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    out_ready = 1'b0;
    tb_fwd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket});
    end
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_count: got %0d required 0", drop_count);
    end
`endif
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ready_after_clock: got %b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_pass_channels();
    logic [7:0] d;
    got.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) begin
        d = 8'(c * 16 + b);
        drive(1'(b == 0), 1'(b == 3), 8'(c), d, 1'b1);
        checks++;
        if ({in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket} !==
            {1'b1, 1'b1, d, 2'(c), 1'(b == 0), 1'(b == 3)}) begin
          errors++;
          $display("FAIL pass_latency c%0d b%0d: got %h required %h", c, b,
                   {in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket},
                   {1'b1, 1'b1, d, 2'(c), 1'(b == 0), 1'(b == 3)});
        end
      end
    end
    idle(3);
    checks++;
    if (got.size() != 16) begin
      errors++;
      $display("FAIL pass_count: got %0d beats required 16", got.size());
    end
  endtask

  task automatic test_drop_between();
    got.delete();
    got_cyc.delete();
    exp.delete();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive(1'(b == 0), 1'(b == 3), 8'd1, 8'(8'h10 + b), 1'b1);
      exp.push_back({8'(8'h10 + b), 2'd1, 1'(b == 0), 1'(b == 3)});
    end
    for (int b = 0; b < 3; b++) drive(1'(b == 0), 1'(b == 2), 8'd5, 8'(8'h50 + b), 1'b0);
    for (int b = 0; b < 4; b++) begin
      drive(1'(b == 0), 1'(b == 3), 8'd1, 8'(8'h20 + b), 1'b1);
      exp.push_back({8'(8'h20 + b), 2'd1, 1'(b == 0), 1'(b == 3)});
    end
    idle(4);
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL drop_between_count: got %0d required %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL drop_between_beat %0d: got %h required %h", i, got[i], exp[i]);
        end
      end
      checks++;
      if ((got_cyc[4] - got_cyc[3]) != 4 || (got_cyc[7] - got_cyc[0]) != 10) begin
        errors++;
        $display("FAIL drop_between_gap: got %0d/%0d required 4/10",
                 got_cyc[4] - got_cyc[3], got_cyc[7] - got_cyc[0]);
      end
    end
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_between_cnt: got %0d required 1", drop_count);
    end
`endif
  endtask

  task automatic test_drop_single();
    got.delete();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'd9, 8'h99, 1'b0);
    drive(1'b0, 1'b0, 8'd1, 8'hAA, 1'b1);
    drive(1'b0, 1'b1, 8'd6, 8'hAB, 1'b0);
    idle(3);
    checks++;
    if (got.size() != 1 || got[0] !== {8'hAA, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drop_single: got %0d beats first %h required 1 beat %h",
               got.size(), (got.size() > 0) ? got[0] : 12'h0, {8'hAA, 2'd1, 1'b0, 1'b0});
    end
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_single_cnt: got %0d required 2", drop_count);
    end
`endif
  endtask

  task automatic test_channel_change();
    logic [7:0] chs[4];
    chs[0] = 8'd2; chs[1] = 8'd2; chs[2] = 8'd7; chs[3] = 8'd7;
    got.delete();
    exp.delete();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive(1'(b == 0), 1'(b == 3), chs[b], 8'(8'h30 + b), 1'b1);
      exp.push_back({8'(8'h30 + b), 2'd2, 1'(b == 0), 1'(b == 3)});
    end
    idle(3);
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL chan_change_count: got %0d required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL chan_change_beat %0d: got %h required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_sop_restart();
    got.delete();
    exp.delete();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'd1, 8'h60, 1'b1);
    drive(1'b0, 1'b0, 8'd1, 8'h61, 1'b1);
    drive(1'b1, 1'b0, 8'd6, 8'h62, 1'b0);
    drive(1'b0, 1'b1, 8'd6, 8'h63, 1'b0);
    drive(1'b1, 1'b1, 8'd3, 8'h64, 1'b1);
    exp.push_back({8'h60, 2'd1, 1'b1, 1'b0});
    exp.push_back({8'h61, 2'd1, 1'b0, 1'b0});
    exp.push_back({8'h64, 2'd3, 1'b1, 1'b1});
    idle(3);
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL sop_restart_count: got %0d required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL sop_restart_beat %0d: got %h required %h", i, got[i], exp[i]);
        end
      end
    end
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd3) begin
      errors++;
      $display("FAIL sop_restart_cnt: got %0d required 3", drop_count);
    end
`endif
  endtask

  task automatic test_random_backpressure();
    logic [11:0] prev;
    logic        prev_stall;
    int          fwd_cnt;
    int          emit_cnt;
    int          stalls;
    bit          done;
    got.delete();
    exp.delete();
    done = 1'b0;
    prev = '0;
    prev_stall = 1'b0;
    fwd_cnt = 0;
    emit_cnt = 0;
    stalls = 0;
    fork
      begin
        for (int p = 0; p < 10; p++) begin
          for (int b = 0; b < 4; b++) begin
            logic [7:0] d;
            d = 8'(8'h40 + p * 4 + b);
            drive(1'(b == 0), 1'(b == 3), 8'(p % 5), d, 1'((p % 5) != 4));
            if ((p % 5) != 4) exp.push_back({d, 2'(p % 5), 1'(b == 0), 1'(b == 3)});
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (prev_stall) begin
            stalls++;
            checks++;
            if ({out_valid, out_data, out_channel, out_startofpacket, out_endofpacket} !== {1'b1, prev}) begin
              errors++;
              $display("FAIL stall_hold: got %h required %h",
                       {out_valid, out_data, out_channel, out_startofpacket, out_endofpacket}, {1'b1, prev});
            end
          end
          checks++;
          if (in_ready !== 1'((fwd_cnt - emit_cnt) != 2)) begin
            errors++;
            $display("FAIL ready_vs_occupancy: got %b required %b (held %0d)",
                     in_ready, 1'((fwd_cnt - emit_cnt) != 2), fwd_cnt - emit_cnt);
          end
          if (in_valid && in_ready && tb_fwd) fwd_cnt++;
          if (out_valid && out_ready) emit_cnt++;
          prev_stall = out_valid && !out_ready;
          prev = {out_data, out_channel, out_startofpacket, out_endofpacket};
        end
      end
    join
    out_ready = 1'b1;
    idle(6);
    checks++;
    if (got.size() != exp.size() || stalls == 0) begin
      errors++;
      $display("FAIL random_count: got %0d beats (%0d stalls) required %0d beats and some stalls",
               got.size(), stalls, exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL random_beat %0d: got %h required %h", i, got[i], exp[i]);
        end
      end
    end
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd5) begin
      errors++;
      $display("FAIL random_cnt: got %0d required 5", drop_count);
    end
`endif
  endtask

  task automatic test_reset_midpacket();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'd2, 8'h70, 1'b1);
    drive(1'b0, 1'b0, 8'd2, 8'h71, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0",
               {in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    exp.delete();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive(1'(b == 0), 1'(b == 3), 8'd0, 8'(8'h80 + b), 1'b1);
      exp.push_back({8'(8'h80 + b), 2'd0, 1'(b == 0), 1'(b == 3)});
    end
    idle(3);
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL midreset_count: got %0d required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL midreset_beat %0d: got %h required %h", i, got[i], exp[i]);
        end
      end
    end
`ifdef DDR2_SYS_CHF_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_cnt: got %0d required 0", drop_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_channels();
    test_drop_between();
    test_drop_single();
    test_channel_change();
    test_sop_restart();
    test_random_backpressure();
    test_reset_midpacket();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr2_sys_st_channel_filter.md
# ddr2_sys_st_channel_filter

Parametrised Avalon-ST channel adapter with packet-level filtering. Sits between an Avalon-ST byte/packet source (e.g. the bytes-to-packets converter) and a narrower-channel sink, in the `ddr2_sys` master path.
- Maps the wide input channel onto a narrow output channel.
- Discards whole packets whose channel exceeds `MAX_CHANNEL`.
- Registers the output through a two-entry skid buffer, so full throughput is kept and no combinational ready path exists.

## Interface
Parameters:
- `DATA_W`, 8, beat data width (bits).
- `IN_CH_W`, 8, input channel width.
- `OUT_CH_W`, 2, output channel width; must satisfy 2^`OUT_CH_W` > `MAX_CHANNEL`.
- `MAX_CHANNEL`, 3, highest channel forwarded.
- `CNT_W`, 16, drop counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_ready`  out  1  sink ready; registered.
- `in_valid`  in  1  beat valid.
- `in_data`  in  `DATA_W`  beat data.
- `in_channel`  in  `IN_CH_W`  channel; sampled at SOP.
- `in_startofpacket`  in  1  first beat.
- `in_endofpacket`  in  1  last beat.
- `out_ready`  in  1  downstream ready.
- `out_valid`  out  1  beat valid; registered.
- `out_data`  out  `DATA_W`  beat data.
- `out_channel`  out  `OUT_CH_W`  latched packet channel, truncated.
- `out_startofpacket`  out  1  first beat.
- `out_endofpacket`  out  1  last beat.
- `drop_count`  out  `CNT_W`  dropped-packet count; exists only with `DDR2_SYS_CHF_DROP_CNT_EN`.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- Filter FSM, advanced on accepted beats only:
  - `IDLE`:
    - SOP with `in_channel <= MAX_CHANNEL`: latch the channel. Go to `PASS`, or stay in `IDLE` if EOP is also set.
    - SOP with `in_channel > MAX_CHANNEL`: go to `DROP`, or stay in `IDLE` if EOP is also set; the beat is discarded.
  - `PASS`:
    - Forward the beat with the latched channel. Mid-packet `in_channel` changes are ignored.
    - EOP: go to `IDLE`.
    - A new SOP restarts the evaluation as in `IDLE`, without an EOP on the old packet.
  - `DROP`:
    - Discard the beat.
    - EOP: go to `IDLE`.
    - A new SOP is evaluated as in `IDLE`.
  - Non-SOP beat in `IDLE` (protocol error): forwarded if `in_channel <= MAX_CHANNEL`, otherwise discarded; the state stays `IDLE`.
- Discarded beats are still consumed (they enter no buffer). `in_ready` depends only on skid occupancy, so dropped traffic drains at one beat per cycle.
- Skid buffer: a main register drives the outputs; a skid register holds one more beat.
  - `in_ready = !skid_valid`.
  - The main register loads when `!out_valid || out_ready`: from skid if `skid_valid`, otherwise from the accepted input beat.
  - A forwarded beat that is accepted while the main register is held goes to skid.
- `out_channel` = the low `OUT_CH_W` bits of the latched channel.

## Timing
- Reset values (asynchronous): `in_ready`=0, then 1 on the first clock after deassertion. All other outputs are 0: `out_valid`, `out_data`, `out_channel`, `out_startofpacket`, `out_endofpacket`, `drop_count`. The FSM returns to `IDLE` and both buffer entries are invalid.
- Latency: a forwarded beat accepted in cycle N is presented in cycle N+1.
- Throughput: one beat per cycle with `out_ready` held high.
- Backpressure: `out_ready` low for two or more cycles with valid input gives `in_ready`=0 in the cycle after skid fills. Nothing is lost or duplicated.
- Output stability: while `out_valid && !out_ready`, all `out_*` are stable.
- Reset mid-packet: any partial packet is abandoned. Downstream may see SOP without EOP, which is accepted behaviour.

## Configuration
- `DDR2_SYS_CHF_DROP_CNT_EN` defined:
  - `drop_count` port and register exist.
  - Increments by 1 on each accepted SOP that enters `DROP` (including SOP+EOP).
  - Saturates at all-ones.
- Not defined: no port and no counter logic. Filtering behaviour is identical.

## Structure
- Package `ddr2_sys_chf_pkg`:
  - FSM enum `chf_state_t` {`IDLE`, `PASS`, `DROP`}.
  - Beat struct typedef with data, channel, sop and eop fields.
- Sub-module `ddr2_sys_st_skid_buf`: the generic two-entry registered skid buffer carrying the beat struct. The filter FSM stays in the top module.

## Test plan
- Channels 0, 1, 2, 3, each a 4-beat packet, `out_ready`=1 -> 16 beats out, 1-cycle latency, `out_channel` 0..3, `in_ready` never low.
- Channel 5, 3 beats, between two channel-1 packets -> only the 8 channel-1 beats emitted; `drop_count`=1; no output bubbles other than the dropped beats.
- Channel 9 SOP+EOP single-beat packet -> no output; `drop_count`=1; FSM back in `IDLE` next cycle.
- Channel 2 packet whose `in_channel` becomes 7 on beat 2 -> all beats emitted with `out_channel`=2.
- `out_ready` toggling with a random 50% duty under continuous input -> output sequence equals the forwarded input sequence. `in_ready` drops only when skid is full, and outputs are held while stalled.
- `reset_n` asserted mid-packet, then a channel-0 packet -> all outputs 0 during reset; the new packet is forwarded intact; `drop_count`=0.
